// File: rtl/alu_add.sv
// 32-bit adder/subtractor slice: combinational result and flags plus a one-cycle registered copy.
// Optional signed saturation is enabled by defining ALU_ADD_SAT_EN (adds the sat input).
module alu_add #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic             sub,
  input  logic             in_valid,
`ifdef ALU_ADD_SAT_EN
  input  logic             sat,
`endif
  output logic [WIDTH-1:0] rd,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic [WIDTH-1:0] rd_q,
  output logic [2:0]       flags_q,
  output logic             out_valid
);

  // Operands are zero-padded up to whole 4-bit lookahead groups.
  localparam int unsigned NumGroups = (WIDTH + 3) / 4;
  localparam int unsigned PadW      = NumGroups * 4;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum_raw;
  logic [PadW-1:0]  a_pad;
  logic [PadW-1:0]  b_pad;
  logic [PadW-1:0]  g;
  logic [PadW-1:0]  p;
  logic [PadW:0]    c;

  logic [WIDTH-1:0] rd_d;
  logic [2:0]       flags_d;
  logic             valid_d;
  logic             valid_q;

  assign b_eff = sub ? ~rs2 : rs2;
  assign a_pad = PadW'(rs1);
  assign b_pad = PadW'(b_eff);
  assign g     = a_pad & b_pad;
  assign p     = a_pad ^ b_pad;

  // Carry-lookahead inside each group, ripple between groups.
  always_comb begin
    c    = '0;
    c[0] = sub;
    for (int unsigned k = 0; k < NumGroups; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
  end

  assign sum_raw  = p[WIDTH-1:0] ^ c[WIDTH-1:0];
  assign carry    = c[WIDTH];
  assign overflow = (rs1[WIDTH-1] == b_eff[WIDTH-1]) && (sum_raw[WIDTH-1] != rs1[WIDTH-1]);

`ifdef ALU_ADD_SAT_EN
  // Overflow still reports the raw result; only rd is clamped.
  always_comb begin
    rd = sum_raw;
    if (sat && overflow) begin
      rd = rs1[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign rd = sum_raw;
`endif

  assign zero = ~|rd;

  always_comb begin
    rd_d    = rd_q;
    flags_d = flags_q;
    valid_d = in_valid;
    if (in_valid) begin
      rd_d    = rd;
      flags_d = {carry, overflow, zero};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      flags_q <= flags_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;

endmodule

// File: tb/tb_alu_add.sv
// Self-checking bench for alu_add: directed boundary vectors, random combinational checks,
// registered-stage tracking and asynchronous reset behaviour against an arithmetic model.
module tb_alu_add;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        sub;
  logic        in_valid;
`ifdef ALU_ADD_SAT_EN
  logic        sat;
`endif
  logic [31:0] rd;
  logic        carry;
  logic        overflow;
  logic        zero;
  logic [31:0] rd_q;
  logic [2:0]  flags_q;
  logic        out_valid;

  int total = 0;
  int bad   = 0;

  alu_add #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs1       (rs1),
    .rs2       (rs2),
    .sub       (sub),
    .in_valid  (in_valid),
`ifdef ALU_ADD_SAT_EN
    .sat       (sat),
`endif
    .rd        (rd),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .rd_q      (rd_q),
    .flags_q   (flags_q),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic sat_now();
`ifdef ALU_ADD_SAT_EN
    return sat;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: exact signed/unsigned arithmetic in 64 bits, returns {rd, carry, overflow, zero}.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s, input logic st);
    longint          sa, sb, sr;
    longint unsigned ua, ub;
    logic [31:0]     r;
    logic            cy, ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    sr = s ? (sa - sb) : (sa + sb);
    ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    cy = s ? (ua >= ub) : ((ua + ub) > 64'd4294967295);
    r  = sr[31:0];
    if (st && ov) r = (sa < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return {r, cy, ov, (r == 32'd0)};
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_random();
    rs1      = rand_op();
    rs2      = rand_op();
    sub      = 1'($urandom_range(0, 1));
`ifdef ALU_ADD_SAT_EN
    sat      = 1'($urandom_range(0, 1));
`endif
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    rs1      = 32'd3;
    rs2      = 32'd4;
    sub      = 1'b0;
`ifdef ALU_ADD_SAT_EN
    sat      = 1'b0;
`endif
    #1;
    total++;
    if ({rd_q, flags_q, out_valid} !== 36'd0) begin
      bad++;
      $display("FAIL reset_state: got rd_q=%h flags_q=%b out_valid=%b want 0", rd_q, flags_q,
               out_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({rd_q, flags_q, out_valid} !== 36'd0) begin
      bad++;
      $display("FAIL reset_hold: got rd_q=%h flags_q=%b out_valid=%b want 0", rd_q, flags_q,
               out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic test_vectors();
    logic [31:0] va [11] = '{32'd1, 32'hFFFF_FFFF, 32'd10, 32'hFFFF_FFF6, 32'd10, 32'hFFFF_FFFF,
                             32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    logic [31:0] vb [11] = '{32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF6, 32'd10, 32'd21, 32'd2,
                             32'd1, 32'd7, 32'd1, 32'd1, 32'd1};
    logic        vs [11] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1};
    logic [34:0] ve [11] = '{{32'd2, 3'b000}, {32'hFFFF_FFFE, 3'b100}, {32'd0, 3'b101},
                             {32'd0, 3'b101}, {32'd31, 3'b000}, {32'd1, 3'b100},
                             {32'h8000_0000, 3'b010}, {32'hFFFF_FFFE, 3'b000},
                             {32'd0, 3'b101}, {32'h7FFF_FFFF, 3'b110},
                             {32'hFFFF_FFFF, 3'b000}};
    for (int i = 0; i < 11; i++) begin
      rs1 = va[i];
      rs2 = vb[i];
      sub = vs[i];
      #1;
      total++;
      if ({rd, carry, overflow, zero} !== ve[i]) begin
        bad++;
        $display("FAIL vector_%0d: got rd=%h c/v/z=%b%b%b want rd=%h c/v/z=%b", i, rd, carry,
                 overflow, zero, ve[i][34:3], ve[i][2:0]);
      end
    end
`ifdef ALU_ADD_SAT_EN
    sat = 1'b1;
    rs1 = 32'h7FFF_FFFF; rs2 = 32'd1; sub = 1'b0;
    #1;
    total++;
    if ({rd, carry, overflow, zero} !== {32'h7FFF_FFFF, 3'b010}) begin
      bad++;
      $display("FAIL sat_pos: got rd=%h c/v/z=%b%b%b want 7fffffff/010", rd, carry, overflow,
               zero);
    end
    rs1 = 32'h8000_0000; rs2 = 32'd1; sub = 1'b1;
    #1;
    total++;
    if ({rd, carry, overflow, zero} !== {32'h8000_0000, 3'b110}) begin
      bad++;
      $display("FAIL sat_neg: got rd=%h c/v/z=%b%b%b want 80000000/110", rd, carry, overflow,
               zero);
    end
    sat = 1'b0;
`endif
  endtask

  task automatic test_comb_random();
    logic [34:0] exp;
    for (int i = 0; i < 400; i++) begin
      drive_random();
      #1;
      exp = model(rs1, rs2, sub, sat_now());
      total++;
      if ({rd, carry, overflow, zero} !== exp) begin
        bad++;
        $display("FAIL comb_random: a=%h b=%h sub=%b got rd=%h cvz=%b%b%b want rd=%h cvz=%b",
                 rs1, rs2, sub, rd, carry, overflow, zero, exp[34:3], exp[2:0]);
      end
    end
  endtask

  task automatic test_pipeline();
    @(negedge clk);
    in_valid = 1'b1; rs1 = 32'd3; rs2 = 32'd4; sub = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({out_valid, rd_q, flags_q} !== {1'b1, 32'd7, 3'b000}) begin
      bad++;
      $display("FAIL pipe_capture: got v=%b rd_q=%h f=%b want 1/7/000", out_valid, rd_q, flags_q);
    end
    @(negedge clk);
    in_valid = 1'b0; rs1 = 32'd9; rs2 = 32'd9;
    @(posedge clk);
    #1;
    total++;
    if ({out_valid, rd_q, flags_q} !== {1'b0, 32'd7, 3'b000}) begin
      bad++;
      $display("FAIL pipe_hold: got v=%b rd_q=%h f=%b want 0/7/000", out_valid, rd_q, flags_q);
    end
  endtask

  task automatic test_back_to_back();
    logic [34:0] m;
    logic [31:0] exp_rd   = rd_q;
    logic [2:0]  exp_flg  = flags_q;
    logic        exp_vld;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive_random();
      in_valid = 1'($urandom_range(0, 3) != 0);
      #1;
      m = model(rs1, rs2, sub, sat_now());
      @(posedge clk);
      exp_vld = in_valid;
      if (in_valid) begin
        exp_rd  = m[34:3];
        exp_flg = m[2:0];
      end
      #1;
      total++;
      if ({out_valid, rd_q, flags_q} !== {exp_vld, exp_rd, exp_flg}) begin
        bad++;
        $display("FAIL back_to_back_%0d: got v=%b rd_q=%h f=%b want v=%b rd_q=%h f=%b", i,
                 out_valid, rd_q, flags_q, exp_vld, exp_rd, exp_flg);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [34:0] exp;
    @(negedge clk);
    in_valid = 1'b1; rs1 = 32'd100; rs2 = 32'd23; sub = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({out_valid, rd_q} !== {1'b1, 32'd123}) begin
      bad++;
      $display("FAIL arst_pre: got v=%b rd_q=%h want 1/0000007b", out_valid, rd_q);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({rd_q, flags_q, out_valid} !== 36'd0) begin
      bad++;
      $display("FAIL arst_immediate: got rd_q=%h f=%b v=%b want 0", rd_q, flags_q, out_valid);
    end
    rs1 = 32'h1234_5678; rs2 = 32'h0000_1111; sub = 1'b1;
    #1;
    exp = model(rs1, rs2, sub, sat_now());
    total++;
    if ({rd, carry, overflow, zero} !== exp) begin
      bad++;
      $display("FAIL arst_comb: got rd=%h cvz=%b%b%b want rd=%h cvz=%b", rd, carry, overflow,
               zero, exp[34:3], exp[2:0]);
    end
    @(posedge clk);
    #1;
    total++;
    if ({rd_q, flags_q, out_valid} !== 36'd0) begin
      bad++;
      $display("FAIL arst_edge: got rd_q=%h f=%b v=%b want 0", rd_q, flags_q, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rs1 = 32'd5; rs2 = 32'd6; sub = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({out_valid, rd_q, flags_q} !== {1'b1, 32'd11, 3'b000}) begin
      bad++;
      $display("FAIL arst_release: got v=%b rd_q=%h f=%b want 1/b/000", out_valid, rd_q,
               flags_q);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_comb_random();
    test_pipeline();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_add.md
Name: alu_add

Overview:
- 32-bit integer adder/subtractor slice of the ALU execute stage.
- Produces a combinational result `rd` from `rs1`/`rs2`, used directly by the datapath.
- Also produces a one-cycle registered copy of the result and flags for the writeback/flag pipeline.
- Results are modulo 2^WIDTH (two's complement wrap).

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥2.

Ports:
- clk  in  1  system clock; rising edge active.
- rst_n  in  1  asynchronous active-low reset.
- rs1  in  WIDTH  operand A.
- rs2  in  WIDTH  operand B.
- sub  in  1  0 = add (rs1+rs2), 1 = subtract (rs1-rs2).
- in_valid  in  1  operands valid this cycle; qualifies the registered stage.
- rd  out  WIDTH  combinational result.
- carry  out  1  combinational carry-out of bit WIDTH-1. For subtract it is the carry of rs1 + ~rs2 + 1, so 1 means no borrow.
- overflow  out  1  combinational signed overflow.
- zero  out  1  combinational; 1 when rd == 0.
- rd_q  out  WIDTH  registered rd.
- flags_q  out  3  registered {carry, overflow, zero}.
- out_valid  out  1  registered in_valid.

Behaviour:
- Core operation: B' = sub ? ~rs2 : rs2; {carry, rd} = rs1 + B' + sub, evaluated at WIDTH+1 bits.
- rd is the low WIDTH bits of that sum; no exception or trap on overflow.
- overflow = (rs1[MSB] == B'[MSB]) && (rd[MSB] != rs1[MSB]).
- zero = ~|rd.
- rd, carry, overflow and zero are purely combinational: zero-cycle latency, independent of clk and rst_n, valid within the same delta after any input change.
- Adder structure: 4-bit carry-lookahead groups with ripple or lookahead between groups. Must meet a single-cycle path at the target clock.
- Registered stage, on the rising edge of clk:
  - out_valid <= in_valid.
  - When in_valid = 1: rd_q <= rd and flags_q <= {carry, overflow, zero}.
  - When in_valid = 0: rd_q and flags_q hold their previous values.
- Latency: 1 cycle from in_valid to out_valid.
- No handshake or backpressure; a new operation may be accepted every cycle.
- Reset:
  - Asserting rst_n = 0 immediately forces rd_q = 0, flags_q = 0 and out_valid = 0, regardless of clk.
  - Deassertion is synchronized externally; the first capture happens on the first rising edge with rst_n = 1.
  - Reset mid-operation discards the in-flight result.
  - Combinational outputs are unaffected by reset.
- Boundaries:
  - 0xFFFFFFFF + 1 = 0, carry = 1, zero = 1, overflow = 0.
  - 0x7FFFFFFF + 1 = 0x80000000, overflow = 1.
  - 0x80000000 - 1 = 0x7FFFFFFF, overflow = 1, carry = 1.
  - 0 - 1 = 0xFFFFFFFF, carry = 0.
- X-propagation: outputs may be X only when inputs are X. Reset values are never X.

Optional Feature:
- Macro: ALU_ADD_SAT_EN.
- When defined:
  - Adds input port `sat` (1 bit).
  - When sat = 1 and overflow = 1, rd is clamped to signed saturation: 0x7FFF...F if rs1 was non-negative, otherwise 0x800...0.
  - zero is computed on the clamped value, and rd_q/flags_q capture the clamped result.
  - The overflow flag still reports the raw overflow.
- When not defined:
  - No `sat` port exists.
  - rd always wraps modulo 2^WIDTH.

Test Plan:
- sub=0, rs1=1, rs2=1 -> rd=2, carry=0, overflow=0, zero=0.
- sub=0, rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> rd=0xFFFFFFFE, carry=1, overflow=0.
- sub=0, (rs1,rs2) = (10, -10) and (-10, 10) -> rd=0, zero=1, carry=1.
- sub=0, (rs1,rs2) = (10, 21) -> rd=31.
- sub=0, (rs1,rs2) = (0xFFFFFFFF, 2) -> rd=1, carry=1.
- sub=0, rs1=0x7FFFFFFF, rs2=1 -> overflow=1. With ALU_ADD_SAT_EN and sat=1, rd=0x7FFFFFFF.
- sub=1, rs1=5, rs2=7 -> rd=0xFFFFFFFE, carry=0, overflow=0.
- Pipeline: drive in_valid=1 with 3+4, then in_valid=0 -> next edge gives out_valid=1, rd_q=7, flags_q=000. The following edge gives out_valid=0 with rd_q held at 7.
- Reset: pull rst_n low between clock edges while out_valid=1 -> rd_q, flags_q and out_valid are 0 immediately, before any clk edge. Combinational rd still tracks the inputs.
